rom_dp_loader: RTL

//  Parametrised dual-port boot/instruction ROM, successor to the single-port fetch ROM.

---
 rtl/rom_pkg.sv | 40 ++++
 rtl/rom_dp_loader_if.sv | 36 +++
 rtl/rom_load_align.sv | 60 ++++++
 rtl/rom_dp_loader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the dual-port boot/instruction ROM:
//   - RV32 load funct3 codes handled by the data port
//   - port B FSM state encoding
//   - NOP word driven on the fetch port during reset/flush
//   - rom_image_word(): the ROM contents, evaluated at elaboration
// ---------------------------------------------------------------------------
package rom_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } rom_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Boot image. Word 5 carries a fixed pattern with a negative byte and
    // half so sign/zero extension is easy to eyeball; the rest is a
    // scrambled function of the index so neighbouring words differ.
    function automatic logic [31:0] rom_image_word(input int unsigned idx);
        logic [31:0] h;
        if (idx == 5) begin
            return 32'h8081_F0FE;
        end
        h = idx * 32'h9E37_79B1 + 32'h1234_5678;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        return h;
    endfunction

endpackage

// File: rtl/rom_dp_loader_if.sv
// ---------------------------------------------------------------------------
// rom_dp_loader_if
// Bundles the fetch port (A) and the load port (B) of rom_dp_loader.
//   master : the core side (IF stage + LSU), drives requests
//   slave  : the ROM, drives data/handshake back
// Port A: ena, flusha, addra -> douta, valida
// Port B: reqb, addrb, funct3b -> busyb, ackb, doutb, errb
// ---------------------------------------------------------------------------
interface rom_dp_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              ena;
    logic              flusha;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;
    logic              valida;

    logic              reqb;
    logic [ADDR_W+1:0] addrb;
    logic [2:0]        funct3b;
    logic              busyb;
    logic              ackb;
    logic [DATA_W-1:0] doutb;
    logic              errb;

    modport master (
        output ena, flusha, addra, reqb, addrb, funct3b,
        input  douta, valida, busyb, ackb, doutb, errb
    );

    modport slave (
        input  ena, flusha, addra, reqb, addrb, funct3b,
        output douta, valida, busyb, ackb, doutb, errb
    );
endinterface

// File: rtl/rom_load_align.sv
// ---------------------------------------------------------------------------
// rom_load_align
// Combinational RV32 load extraction from a 32-bit word.
//   i_word     : full memory word
//   i_offset   : byte lane (byte address bits [1:0])
//   i_funct3   : load type (LB/LH/LW/LBU/LHU)
//   o_data     : extracted, sign/zero extended result
//   o_misalign : halfword on odd lane, or word on nonzero lane
//   o_illegal  : funct3 is not a supported load
// ---------------------------------------------------------------------------
module rom_load_align
    import rom_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'h0, w_byte};
            F3_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_offset[0];
            end
            F3_LHU: begin
                o_data     = {16'h0, w_half};
                o_misalign = i_offset[0];
            end
            F3_LW: begin
                o_data     = i_word;
                o_misalign = (i_offset != 2'b00);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rom_dp_loader.sv
// ---------------------------------------------------------------------------
// rom_dp_loader
// Dual-port boot/instruction ROM.
//   i_clka  : clock, all logic on rising edge
//   i_rsta  : synchronous reset, active high
//   io_rom  : rom_dp_loader_if.slave
//     port A (fetch, latency 1): ena stalls, flusha injects a NOP bubble
//     port B (load): level reqb, one-cycle ackb two cycles after acceptance,
//                    doutb/errb valid only with ackb
//
// Port B FSM
//   state   | meaning
//   IDLE    | waiting for reqb; latches address/funct3 on acceptance
//   READ    | word read from ROM, error flags resolved
//   RESP    | ackb high for this cycle, doutb/errb valid
// ---------------------------------------------------------------------------
module rom_dp_loader
    import rom_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 512,
    parameter int                ADDR_W     = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] RESET_WORD = NOP_WORD
) (
    input logic          i_clka,
    input logic          i_rsta,
    rom_dp_loader_if.slave io_rom
);

    if (DATA_W != 32) begin : g_bad_width
        $error("rom_dp_loader: DATA_W must be 32");
    end

    // One extra bit so DEPTH itself is representable even for power-of-two depths.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] w_mem [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_mem[g] = rom_image_word(g);
    end

    // ---------------- port A ----------------
    logic [DATA_W-1:0] r_douta;
    logic              r_valida;
    logic              w_a_in_range;

    assign w_a_in_range = ({1'b0, io_rom.addra} < DEPTH_LIM);

    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_douta  <= RESET_WORD;
            r_valida <= 1'b0;
        end else if (io_rom.flusha) begin
            r_douta  <= RESET_WORD;
            r_valida <= 1'b0;
        end else if (io_rom.ena) begin
            // Out-of-range fetches still count as valid so the core executes a NOP.
            r_douta  <= w_a_in_range ? w_mem[io_rom.addra] : RESET_WORD;
            r_valida <= 1'b1;
        end
    end

    assign io_rom.douta  = r_douta;
    assign io_rom.valida = r_valida;

    // ---------------- port B ----------------
    rom_state_e        r_state;
    logic [ADDR_W-1:0] r_b_idx;
    logic [1:0]        r_b_lane;
    logic [2:0]        r_b_f3;
    logic              r_b_range_err;
    logic [DATA_W-1:0] r_b_word;
    logic              r_busyb;
    logic              r_ackb;
    logic              r_errb;

    logic [ADDR_W-1:0] w_b_idx;
    logic [31:0]       w_align_data;
    logic              w_misalign;
    logic              w_illegal;

    assign w_b_idx = io_rom.addrb[ADDR_W+1:2];

    rom_load_align u_align (
        .i_word     (r_b_word),
        .i_offset   (r_b_lane),
        .i_funct3   (r_b_f3),
        .o_data     (w_align_data),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_state       <= ST_IDLE;
            r_busyb       <= 1'b0;
            r_ackb        <= 1'b0;
            r_errb        <= 1'b0;
            r_b_idx       <= '0;
            r_b_lane      <= '0;
            r_b_f3        <= '0;
            r_b_range_err <= 1'b0;
            r_b_word      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ackb <= 1'b0;
                    r_errb <= 1'b0;
                    if (io_rom.reqb) begin
                        r_b_idx       <= w_b_idx;
                        r_b_lane      <= io_rom.addrb[1:0];
                        r_b_f3        <= io_rom.funct3b;
                        r_b_range_err <= ({1'b0, w_b_idx} >= DEPTH_LIM);
                        r_busyb       <= 1'b1;
                        r_state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Lane/funct3 flags depend only on latched fields, so the
                    // error is known in the same cycle the word is read.
                    r_b_word <= r_b_range_err ? '0 : w_mem[r_b_idx];
                    r_errb   <= r_b_range_err | w_misalign | w_illegal;
                    r_ackb   <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_ackb  <= 1'b0;
                    r_errb  <= 1'b0;
                    r_busyb <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ackb  <= 1'b0;
                    r_errb  <= 1'b0;
                    r_busyb <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_rom.busyb = r_busyb;
    assign io_rom.ackb  = r_ackb;
    assign io_rom.errb  = r_errb;
    // Data is forced to zero outside RESP and on any error.
    assign io_rom.doutb = (r_ackb && !r_errb) ? w_align_data : '0;

endmodule
